button_history_display: RTL and testbench

BUTTON_HISTORY_DISPLAY -- requirements
Module: button_history_display

---
 rtl/button_history_display.sv | 149 ++++++++++++++
 tb/tb_button_history_display.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_history_display.sv
// Debounced button history with seven-segment rendering.
//
// A raw 3-bit button code is debounced. Each accepted nonzero code is pushed
// into a newest-first history of DEPTH slots, and each slot is rendered as two
// active-low seven-segment glyphs. The history clears on request, or by itself
// after TIMEOUT idle cycles. Slot 0 can blink with a half-period of BLINK_HALF
// cycles.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   val[2:0]     raw button code, 000 = no button
//   clear        synchronous history clear (beats a simultaneous press)
//   blink_en     allow slot 0 to blink while the history is not empty
//   seg          14 bits per slot {seg1, seg0}, bit order gfedcba, active low
//   count[3:0]   number of occupied slots
//   press_pulse  one-cycle strobe per accepted press

module button_history_display #(
   parameter int DEPTH         = 3,
   parameter int STABLE_CYCLES = 500000,
   parameter int TIMEOUT       = 250000000,
   parameter int BLINK_HALF    = 25000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           val,
   input  logic                 clear,
   input  logic                 blink_en,
   output logic [14*DEPTH-1:0]  seg,
   output logic [3:0]           count,
   output logic                 press_pulse
);

   localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT - 1);
   localparam logic [BW-1:0] BLNK_MAX = BW'(BLINK_HALF - 1);
   localparam logic [3:0]    DEPTH_C  = 4'(DEPTH);

   logic [2:0]          val_q;
   logic [2:0]          deb;
   logic [SW-1:0]       stab_cnt;
   logic [TW-1:0]       idle_cnt;
   logic [BW-1:0]       blink_cnt;
   logic                blink_on;
   logic [2:0]          slot [DEPTH];
   logic [14*DEPTH-1:0] seg_d;

   logic deb_upd;
   logic press;
   logic timeout;

   // The debounced code only moves once val_q has been stable for
   // STABLE_CYCLES samples. A release updates deb but is not a press.
   assign deb_upd = (stab_cnt == STAB_MAX) && (val_q != deb);
   assign press   = deb_upd && (val_q != 3'd0) && !clear;
   // This fires on the edge where the idle timer reaches IDLE_MAX, and
   // again on every later edge while it is held there.
   assign timeout = !press && !clear && (idle_cnt >= IDLE_MAX - TW'(1));

   function automatic logic [13:0] glyph(input logic [2:0] code);
      logic [13:0] g;
      case (code)
         3'd1:    g = {7'b1111111, 7'b0001000};
         3'd2:    g = {7'b1111111, 7'b1100000};
         3'd3:    g = {7'b0100100, 7'b0110000};
         3'd4:    g = {7'b1000001, 7'b0011000};
         3'd5:    g = {7'b1111111, 7'b1000010};
         3'd6:    g = {7'b1111111, 7'b1110001};
         3'd7:    g = {7'b0111001, 7'b1111001};
         default: g = {14{1'b1}};
      endcase
      return g;
   endfunction

   // clear and timeout deliberately do not touch the debounce state.
   always_ff @(posedge clk) begin
      if (rst) begin
         val_q       <= 3'd0;
         stab_cnt    <= '0;
         deb         <= 3'd0;
         press_pulse <= 1'b0;
      end else begin
         val_q <= val;
         if (val != val_q)
            stab_cnt <= '0;
         else if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + SW'(1);
         if (deb_upd)
            deb <= val_q;
         press_pulse <= press;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) slot[k] <= 3'd0;
         count <= 4'd0;
      end else if (press) begin
         slot[0] <= val_q;
         for (int k = 1; k < DEPTH; k++) slot[k] <= slot[k-1];
         if (count != DEPTH_C)
            count <= count + 4'd1;
      end else if (clear || timeout) begin
         for (int k = 0; k < DEPTH; k++) slot[k] <= 3'd0;
         count <= 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || press || clear)
         idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
         idle_cnt <= idle_cnt + TW'(1);
   end

   // The blink phase runs freely and restarts in the on phase at every press.
   always_ff @(posedge clk) begin
      if (rst || press) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (blink_cnt == BLNK_MAX) begin
         blink_cnt <= '0;
         blink_on  <= !blink_on;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   always_comb begin
      seg_d = '1;
      for (int k = 0; k < DEPTH; k++)
         seg_d[14*k +: 14] = glyph(slot[k]);
      if (blink_en && (count != 4'd0) && !blink_on)
         seg_d[13:0] = {14{1'b1}};
   end

   always_ff @(posedge clk) begin
      if (rst)
         seg <= '1;
      else
         seg <= seg_d;
   end

endmodule

// File: tb/tb_button_history_display.sv
module tb_button_history_display;

   localparam int DEPTH = 3;
   localparam int S     = 4;
   localparam int TO    = 20;
   localparam int BH    = 5;
   localparam logic [41:0] ALL1 = {42{1'b1}};

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [2:0]        val = 3'd0;
   logic              clear = 1'b0;
   logic              blink_en = 1'b0;
   logic [14*DEPTH-1:0] seg;
   logic [3:0]        count;
   logic              press_pulse;

   int vectors = 0;
   int miscompares = 0;
   int npulse = 0;

   button_history_display #(
      .DEPTH(DEPTH), .STABLE_CYCLES(S), .TIMEOUT(TO), .BLINK_HALF(BH)
   ) dut (
      .clk(clk), .rst(rst), .val(val), .clear(clear), .blink_en(blink_en),
      .seg(seg), .count(count), .press_pulse(press_pulse)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int   q[$] = '{0};      // most recent raw samples (at most S)
   int   deb_m = 0;
   int   slots_m[DEPTH];
   int   count_m = 0;
   int   idle_m = 0;        // cycles since last press/clear/reset, capped
   int   tsince = 0;        // cycles since last press/reset (blink phase)
   bit   pulse_m = 0;
   logic [41:0] seg_m = ALL1;
   int   edges = 0;

   function automatic logic [13:0] gl(input int code);
      case (code)
         1: return {7'b1111111, 7'b0001000};
         2: return {7'b1111111, 7'b1100000};
         3: return {7'b0100100, 7'b0110000};
         4: return {7'b1000001, 7'b0011000};
         5: return {7'b1111111, 7'b1000010};
         6: return {7'b1111111, 7'b1110001};
         7: return {7'b0111001, 7'b1111001};
         default: return {14{1'b1}};
      endcase
   endfunction

   function automatic logic [41:0] render(input bit ben);
      logic [41:0] r;
      r = ALL1;
      for (int k = 0; k < DEPTH; k++) r[14*k +: 14] = gl(slots_m[k]);
      if (ben && count_m > 0 && ((tsince / BH) % 2) == 1) r[13:0] = {14{1'b1}};
      return r;
   endfunction

   always @(posedge clk) begin
      logic [41:0] nseg;
      bit acc, prs;
      int c;
      edges++;
      if (rst) begin
         q = '{0};
         deb_m = 0;
         foreach (slots_m[k]) slots_m[k] = 0;
         count_m = 0; idle_m = 0; tsince = 0; pulse_m = 0; seg_m = ALL1;
      end else begin
         nseg = render(blink_en);
         c = q[q.size()-1];
         acc = (q.size() >= S) && (c != deb_m);
         foreach (q[i]) if (q[i] != c) acc = 0;
         q.push_back(int'(val));
         if (q.size() > S) void'(q.pop_front());
         prs = acc && (c != 0) && !clear;
         if (acc) deb_m = c;
         pulse_m = prs;
         if (prs) begin
            for (int k = DEPTH-1; k > 0; k--) slots_m[k] = slots_m[k-1];
            slots_m[0] = c;
            if (count_m < DEPTH) count_m++;
            idle_m = 0; tsince = 0;
         end else begin
            tsince++;
            if (clear) begin
               foreach (slots_m[k]) slots_m[k] = 0;
               count_m = 0; idle_m = 0;
            end else begin
               if (idle_m < TO-1) idle_m++;
               if (idle_m == TO-1) begin
                  foreach (slots_m[k]) slots_m[k] = 0;
                  count_m = 0;
               end
            end
         end
         seg_m = nseg;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (edges > 0) begin
         chk("seg", 64'(seg), 64'(seg_m));
         chk("count", 64'(count), 64'(count_m));
         chk("press_pulse", 64'(press_pulse), 64'(pulse_m));
         if (press_pulse === 1'b1) npulse++;
      end
   end

   task automatic step(input logic [2:0] v, input logic c);
      @(negedge clk);
      val = v;
      clear = c;
   endtask

   task automatic hold(input logic [2:0] v, input int n);
      for (int i = 0; i < n; i++) step(v, 1'b0);
   endtask

   initial begin
      int p0;
      logic [13:0] on7;
      on7 = {7'b0111001, 7'b1111001};

      rst = 1'b1;
      hold(3'd0, 3);
      chk("reset_seg", 64'(seg), 64'(ALL1));
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_pulse", 64'(press_pulse), 64'd0);
      rst = 1'b0;

      // single held press
      p0 = npulse;
      hold(3'd1, 10);
      chk("hold_pulses", 64'(npulse - p0), 64'd1);
      chk("hold_count", 64'(count), 64'd1);
      chk("hold_seg", 64'(seg), 64'({28'hFFFFFFF, 14'b1111111_0001000}));
      hold(3'd0, 6);

      // glitch rejection
      step(3'd0, 1'b1);
      p0 = npulse;
      hold(3'd1, 2);
      hold(3'd0, 8);
      chk("glitch_pulses", 64'(npulse - p0), 64'd0);
      chk("glitch_count", 64'(count), 64'd0);

      // history overflow
      for (int c = 1; c <= 4; c++) begin
         hold(3'(c), 8);
         if (c < 4) hold(3'd0, 6);
      end
      chk("ovf_count", 64'(count), 64'd3);
      chk("ovf_seg", 64'(seg), 64'({gl(2), gl(3), gl(4)}));

      // idle timeout
      hold(3'd0, 25);
      chk("timeout_count", 64'(count), 64'd0);
      chk("timeout_seg", 64'(seg), 64'(ALL1));

      // clear on the acceptance edge
      p0 = npulse;
      hold(3'd1, 4);
      step(3'd1, 1'b1);
      hold(3'd1, 3);
      chk("clrwin_pulses", 64'(npulse - p0), 64'd0);
      chk("clrwin_count", 64'(count), 64'd0);
      chk("clrwin_seg", 64'(seg), 64'(ALL1));
      hold(3'd0, 6);

      // blinking newest slot
      hold(3'd2, 8);
      hold(3'd0, 8);
      blink_en = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         step(3'd7, 1'b0);
         if (k == 6) chk("blink_pulse", 64'(press_pulse), 64'd1);
         if (k >= 7) begin
            chk("blink_slot0", 64'(seg[13:0]),
                64'((((k - 7) / 5) % 2 == 0) ? on7 : {14{1'b1}}));
            chk("blink_slot1", 64'(seg[27:14]), 64'({7'b1111111, 7'b1100000}));
         end
      end
      blink_en = 1'b0;
      hold(3'd0, 6);

      // randomized traffic
      for (int r = 0; r < 300; r++) begin
         int code, len;
         code = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 7);
         len  = (code == 0 && $urandom_range(0, 4) == 0) ? $urandom_range(15, 30)
                                                          : $urandom_range(1, 9);
         blink_en = 1'($urandom_range(0, 1));
         for (int i = 0; i < len; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            step(3'(code), ($urandom_range(0, 39) == 0));
         end
         rst = 1'b0;
      end
      step(3'd0, 1'b0);
      step(3'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
